// File: rtl/mult_acc_pkg.sv
// Shared definitions for the multiply-accumulate datapath: FSM encoding and default widths.
`timescale 1ns/1ps
package mult_acc_pkg;

    localparam int unsigned DEF_ACC_WIDTH   = 24;
    localparam int unsigned DEF_COUNT_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_HOLD  = 2'd2
    } acc_state_e;

endpackage

// File: rtl/acc_add_clamp.sv
// Combinational accumulator adder with carry out.
// Build option: PRODUCT_ACC_SATURATE_EN clamps the sum to all-ones on carry instead of wrapping.
`timescale 1ns/1ps
module acc_add_clamp
    import mult_acc_pkg::*;
#(
    parameter int unsigned ACC_WIDTH     = DEF_ACC_WIDTH,
    parameter int unsigned PRODUCT_WIDTH = 16
) (
    input  logic [ACC_WIDTH-1:0]     acc_i,
    input  logic [PRODUCT_WIDTH-1:0] product_i,
    output logic [ACC_WIDTH-1:0]     sum_o,
    output logic                     carry_o
);

    localparam int unsigned SUM_WIDTH = ACC_WIDTH + 1;

    logic [SUM_WIDTH-1:0] full_sum;

    always_comb begin
        full_sum = SUM_WIDTH'(acc_i) + SUM_WIDTH'(product_i);
        carry_o  = full_sum[ACC_WIDTH];
`ifdef PRODUCT_ACC_SATURATE_EN
        // Once clamped, any further non-zero term carries again, so the clamp holds.
        sum_o    = carry_o ? {ACC_WIDTH{1'b1}} : full_sum[ACC_WIDTH-1:0];
`else
        sum_o    = full_sum[ACC_WIDTH-1:0];
`endif
    end

endmodule

// File: rtl/product_accumulator.sv
// Per-frame accumulator of unsigned products with a registered valid/ready result port.
// Build option: PRODUCT_ACC_SATURATE_EN (see acc_add_clamp) selects clamping over wrapping.
`timescale 1ns/1ps
module product_accumulator
    import mult_acc_pkg::*;
#(
    parameter int unsigned A0_WIDTH    = 8,
    parameter int unsigned A1_WIDTH    = 8,
    parameter int unsigned ACC_WIDTH   = DEF_ACC_WIDTH,
    parameter int unsigned COUNT_WIDTH = DEF_COUNT_WIDTH
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           clear,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [A0_WIDTH+A1_WIDTH-1:0]   in_product,
    input  logic                           in_last,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [ACC_WIDTH-1:0]           out_sum,
    output logic [COUNT_WIDTH-1:0]         out_count,
    output logic                           out_overflow
);

    localparam int unsigned PRODUCT_WIDTH = A0_WIDTH + A1_WIDTH;

    acc_state_e             state_q,     state_d;
    logic [ACC_WIDTH-1:0]   acc_q,       acc_d;
    logic [COUNT_WIDTH-1:0] count_q,     count_d;
    logic                   ovf_q,       ovf_d;
    logic                   out_valid_q, out_valid_d;
    logic [ACC_WIDTH-1:0]   out_sum_q,   out_sum_d;
    logic [COUNT_WIDTH-1:0] out_count_q, out_count_d;
    logic                   out_ovf_q,   out_ovf_d;

    logic [ACC_WIDTH-1:0]   add_sum;
    logic                   add_carry;
    logic [COUNT_WIDTH-1:0] count_inc;
    logic                   accept;

    acc_add_clamp #(
        .ACC_WIDTH     (ACC_WIDTH),
        .PRODUCT_WIDTH (PRODUCT_WIDTH)
    ) u_add (
        .acc_i     (acc_q),
        .product_i (in_product),
        .sum_o     (add_sum),
        .carry_o   (add_carry)
    );

    // Ready depends on registered state only, never on out_ready.
    assign in_ready     = (state_q != ST_HOLD);
    assign out_valid    = out_valid_q;
    assign out_sum      = out_sum_q;
    assign out_count    = out_count_q;
    assign out_overflow = out_ovf_q;

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        count_d     = count_q;
        ovf_d       = ovf_q;
        out_valid_d = out_valid_q;
        out_sum_d   = out_sum_q;
        out_count_d = out_count_q;
        out_ovf_d   = out_ovf_q;

        accept    = in_valid && in_ready;
        count_inc = (count_q == {COUNT_WIDTH{1'b1}}) ? count_q : count_q + COUNT_WIDTH'(1);

        // clear outranks every other event, including a same-cycle accept.
        if (clear) begin
            state_d     = ST_IDLE;
            acc_d       = '0;
            count_d     = '0;
            ovf_d       = 1'b0;
            out_valid_d = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE, ST_ACCUM: begin
                    if (accept) begin
                        acc_d   = add_sum;
                        count_d = count_inc;
                        ovf_d   = ovf_q | add_carry;
                        if (in_last) begin
                            out_sum_d   = add_sum;
                            out_count_d = count_inc;
                            out_ovf_d   = ovf_q | add_carry;
                            out_valid_d = 1'b1;
                            state_d     = ST_HOLD;
                        end else begin
                            state_d = ST_ACCUM;
                        end
                    end
                end
                ST_HOLD: begin
                    if (out_ready) begin
                        acc_d       = '0;
                        count_d     = '0;
                        ovf_d       = 1'b0;
                        out_valid_d = 1'b0;
                        state_d     = ST_IDLE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            acc_q       <= '0;
            count_q     <= '0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_sum_q   <= '0;
            out_count_q <= '0;
            out_ovf_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            count_q     <= count_d;
            ovf_q       <= ovf_d;
            out_valid_q <= out_valid_d;
            out_sum_q   <= out_sum_d;
            out_count_q <= out_count_d;
            out_ovf_q   <= out_ovf_d;
        end
    end

endmodule

// File: tb/tb_product_accumulator.sv
// Self-checking bench for product_accumulator: directed frames plus randomized frames
// compared against a frame-level arithmetic model (ACC_WIDTH=16, COUNT_WIDTH=2).
`timescale 1ns/1ps
module tb_product_accumulator;

    localparam int unsigned AW = 16;
    localparam int unsigned CW = 2;
    localparam longint ACC_MOD = 64'd65536;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          clear = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [15:0]   in_product = '0;
    logic          in_last = 1'b0;
    logic          out_valid;
    logic          out_ready;
    logic [AW-1:0] out_sum;
    logic [CW-1:0] out_count;
    logic          out_overflow;

    int n_checks = 0;
    int n_fail   = 0;

    bit   rand_ready_en  = 1'b0;
    logic directed_ready = 1'b1;
    logic rand_bit       = 1'b0;
    bit   chk_en         = 1'b0;

    product_accumulator #(
        .A0_WIDTH    (8),
        .A1_WIDTH    (8),
        .ACC_WIDTH   (AW),
        .COUNT_WIDTH (CW)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .clear        (clear),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_product   (in_product),
        .in_last      (in_last),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_sum      (out_sum),
        .out_count    (out_count),
        .out_overflow (out_overflow)
    );

    always #5 clk = ~clk;

    always @(negedge clk) rand_bit = 1'($urandom_range(0, 1));
    assign out_ready = rand_ready_en ? rand_bit : directed_ready;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Frame-level model: the total and term count of the open frame, and the result it implies.
    longint      m_total = 0;
    int          m_n     = 0;
    bit          m_hold  = 1'b0;
    logic [15:0] m_sum   = '0;
    logic [1:0]  m_cnt   = '0;
    logic        m_ovf   = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_total = 0; m_n = 0; m_hold = 1'b0;
        end else if (clear) begin
            m_total = 0; m_n = 0; m_hold = 1'b0;
        end else if (m_hold) begin
            if (out_ready) begin
                m_total = 0; m_n = 0; m_hold = 1'b0;
            end
        end else if (in_valid) begin
            m_total = m_total + longint'(in_product);
            m_n     = m_n + 1;
            if (in_last) begin
                m_hold = 1'b1;
                m_ovf  = (m_total >= ACC_MOD);
`ifdef PRODUCT_ACC_SATURATE_EN
                m_sum  = m_ovf ? 16'hFFFF : 16'(m_total);
`else
                m_sum  = 16'(m_total % ACC_MOD);
`endif
                m_cnt  = (m_n > 3) ? 2'd3 : 2'(m_n);
            end
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            check("out_valid", 64'(out_valid), 64'(m_hold));
            check("in_ready", 64'(in_ready), 64'(!m_hold));
            if (m_hold) begin
                check("out_sum", 64'(out_sum), 64'(m_sum));
                check("out_count", 64'(out_count), 64'(m_cnt));
                check("out_overflow", 64'(out_overflow), 64'(m_ovf));
            end
        end
    end

    task automatic send(input logic [15:0] p, input logic last);
        bit rdy;
        in_valid   = 1'b1;
        in_product = p;
        in_last    = last;
        for (int i = 0; i < 60; i++) begin
            rdy = (in_ready === 1'b1);
            @(negedge clk);
            if (rdy) begin
                in_valid = 1'b0;
                in_last  = 1'b0;
                return;
            end
        end
        n_checks++;
        n_fail++;
        $display("FAIL send_timeout: product %0h never accepted", p);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_result(input string name, input logic [15:0] s, input logic [1:0] c,
                               input logic o);
        for (int i = 0; i < 60; i++) begin
            if (out_valid === 1'b1) begin
                check({name, "_sum"}, 64'(out_sum), 64'(s));
                check({name, "_count"}, 64'(out_count), 64'(c));
                check({name, "_ovf"}, 64'(out_overflow), 64'(o));
                return;
            end
            @(negedge clk);
        end
        n_checks++;
        n_fail++;
        $display("FAIL %s_timeout: out_valid got 0, expected 1", name);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        #2 rst_n = 1'b0;
        #1;
        check("rst_valid", 64'(out_valid), 64'd0);
        check("rst_sum", 64'(out_sum), 64'd0);
        check("rst_count", 64'(out_count), 64'd0);
        check("rst_ovf", 64'(out_overflow), 64'd0);
        check("rst_ready", 64'(in_ready), 64'd1);
        repeat (2) @(negedge clk);
        rst_n  = 1'b1;
        chk_en = 1'b1;
        @(negedge clk);

        // Simple frame
        send(16'd10, 1'b0);
        send(16'd20, 1'b0);
        send(16'd30, 1'b1);
        wait_result("simple", 16'd60, 2'd3, 1'b0);
        @(negedge clk);

        // Back-pressure with a stalled follow-on product
        directed_ready = 1'b0;
        send(16'd10, 1'b0);
        send(16'd20, 1'b0);
        send(16'd30, 1'b1);
        in_valid = 1'b1; in_product = 16'd7; in_last = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check("bp_ready", 64'(in_ready), 64'd0);
            check("bp_valid", 64'(out_valid), 64'd1);
            check("bp_sum", 64'(out_sum), 64'd60);
            @(negedge clk);
        end
        directed_ready = 1'b1;
        @(negedge clk);
        check("bp_release_ready", 64'(in_ready), 64'd1);
        check("bp_release_valid", 64'(out_valid), 64'd0);
        @(negedge clk);
        in_valid = 1'b0; in_last = 1'b0;
        wait_result("bp_next", 16'd7, 2'd1, 1'b0);
        @(negedge clk);

        // Overflow
        send(16'hFFFF, 1'b0);
        send(16'h0002, 1'b1);
`ifdef PRODUCT_ACC_SATURATE_EN
        wait_result("ovf", 16'hFFFF, 2'd2, 1'b1);
`else
        wait_result("ovf", 16'h0001, 2'd2, 1'b1);
`endif
        @(negedge clk);

        // Count saturation
        for (int i = 0; i < 6; i++) send(16'd1, (i == 5));
        wait_result("cnt_sat", 16'd6, 2'd3, 1'b0);
        @(negedge clk);

        // clear colliding with a last accept
        clear = 1'b1; in_valid = 1'b1; in_product = 16'd9; in_last = 1'b1;
        @(negedge clk);
        clear = 1'b0; in_valid = 1'b0; in_last = 1'b0;
        check("clr_valid", 64'(out_valid), 64'd0);
        send(16'd5, 1'b1);
        wait_result("clr_next", 16'd5, 2'd1, 1'b0);
        @(negedge clk);

        // Reset mid-frame
        send(16'd3, 1'b0);
        send(16'd4, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        check("mrst_valid", 64'(out_valid), 64'd0);
        check("mrst_sum", 64'(out_sum), 64'd0);
        check("mrst_count", 64'(out_count), 64'd0);
        check("mrst_ovf", 64'(out_overflow), 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        send(16'd4, 1'b0);
        send(16'd5, 1'b1);
        wait_result("mrst_next", 16'd9, 2'd2, 1'b0);
        @(negedge clk);

        // Randomized frames with random back-pressure and occasional clear
        rand_ready_en = 1'b1;
        for (int f = 0; f < 300; f++) begin
            int len;
            len = int'($urandom_range(1, 8));
            for (int k = 0; k < len; k++) begin
                logic [15:0] p;
                if ($urandom_range(0, 3) == 0) @(negedge clk);
                if ($urandom_range(0, 40) == 0) begin
                    clear      = 1'b1;
                    in_valid   = 1'($urandom_range(0, 1));
                    in_last    = 1'($urandom_range(0, 1));
                    in_product = 16'($urandom);
                    @(negedge clk);
                    clear    = 1'b0;
                    in_valid = 1'b0;
                    in_last  = 1'b0;
                end
                p = ($urandom_range(0, 3) == 0) ? 16'(16'hFFFF - 16'($urandom_range(0, 15)))
                                                 : 16'($urandom);
                send(p, (k == len - 1));
            end
        end
        rand_ready_en  = 1'b0;
        directed_ready = 1'b1;
        repeat (4) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/product_accumulator.md
# product_accumulator

Accumulates a stream of unsigned products from the `multiplier` stage into one sum per frame, and outputs each sum through a valid/ready handshake. It sits directly downstream of `multiplier`: its input width matches `product`, and the frame boundary is marked by an upstream `last` flag. The block is the sequential back end of the multiply-accumulate datapath.

## Interface
- `A0_WIDTH`, default 8: width of multiplier operand a0.
- `A1_WIDTH`, default 8: width of multiplier operand a1.
- `PRODUCT_WIDTH`, localparam = `A0_WIDTH+A1_WIDTH`: width of the incoming product.
- `ACC_WIDTH`, default 24: accumulator width; must be at least `PRODUCT_WIDTH`.
- `COUNT_WIDTH`, default 8: width of the per-frame term counter.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `clear`  in  1  synchronous frame abort.
- `in_valid`  in  1  product available.
- `in_ready`  out  1  block can accept a product.
- `in_product`  in  `PRODUCT_WIDTH`  unsigned product from `multiplier`.
- `in_last`  in  1  final product of the frame.
- `out_valid`  out  1  `out_sum` is valid.
- `out_ready`  in  1  consumer accepts the result.
- `out_sum`  out  `ACC_WIDTH`  frame sum.
- `out_count`  out  `COUNT_WIDTH`  number of products in the frame, saturating.
- `out_overflow`  out  1  the sum exceeded `ACC_WIDTH` at some point in the frame.

## Operation
- **FSM states:** IDLE, ACCUM, HOLD.
- **Reset:** state IDLE; `acc`, `count` and the overflow flag are 0; `out_valid`=0, `out_sum`=0, `out_count`=0, `out_overflow`=0.
- **Ready:** `in_ready`=1 in IDLE and ACCUM, 0 in HOLD. A product is accepted when `in_valid && in_ready`.
- **Accept without `in_last`:**
  - `acc` <= `acc` + zero-extended `in_product`.
  - `count` <= `count`+1, saturating at all-ones.
  - State goes to ACCUM.
- **Accept with `in_last`:**
  - The same update is made, then the registered result is loaded into `out_sum`/`out_count`/`out_overflow`.
  - State goes to HOLD.
  - A single-product frame (IDLE, `in_last`) is legal.
- **HOLD:** `out_valid`=1 and the outputs stay stable until `out_ready`=1. On that handshake, `acc`, `count` and the flag clear, `out_valid` drops, and the state returns to IDLE.
- **Overflow:** a carry out of bit `ACC_WIDTH-1` sets the sticky overflow flag. Arithmetic on overflow is given under Configuration.
- **`clear`:** has priority over every other event.
  - In any state, `acc`, `count` and the flag go to 0, `out_valid` drops, and the state goes to IDLE.
  - A product presented in the same cycle is discarded.
- `in_valid` while `in_ready`=0 is simply held off; no data is lost upstream.

## Timing
- Latency: `out_valid` rises on the cycle after the `in_last` accept.
- Throughput: one product per cycle within a frame, plus at least one bubble cycle per frame (HOLD).
- All outputs are registered. `in_ready` is a decode of the registered state only, with no combinational path from `out_ready`.
- If `rst_n` is asserted mid-frame, the partial sum is lost and the block is in the reset state immediately.

## Configuration
- `PRODUCT_ACC_SATURATE_EN` defined: on overflow, `acc` clamps to all-ones and holds there for the rest of the frame; `out_overflow` is still set.
- Not defined: `acc` wraps modulo 2^`ACC_WIDTH`; `out_overflow` is set.

## Structure
- Shared package `mult_acc_pkg` holds:
  - the FSM state encoding (IDLE=2'd0, ACCUM=2'd1, HOLD=2'd2);
  - default widths (`DEF_ACC_WIDTH`=24, `DEF_COUNT_WIDTH`=8).
- One sub-module, `acc_add_clamp`: combinational add of `ACC_WIDTH` plus zero-extended product, producing the next sum and a carry. The saturate option lives only inside this sub-module.

## Test plan
- **Simple frame:** products 10, 20, 30 (last on 30), `out_ready`=1 → `out_valid` 1 cycle after the last accept; `out_sum`=60, `out_count`=3, `out_overflow`=0.
- **Back-pressure:** same frame with `out_ready`=0 for 5 cycles → outputs stable, `in_ready`=0 throughout, new `in_valid` stalled. Release → handshake, then IDLE with `in_ready`=1.
- **Overflow:** `ACC_WIDTH`=16, products 0xFFFF and 0x0002 (last):
  - without the macro → `out_sum`=0x0001, `out_overflow`=1;
  - with `PRODUCT_ACC_SATURATE_EN` → `out_sum`=0xFFFF, `out_overflow`=1.
- **`clear` collision:** `clear` in the same cycle as an `in_last` accept → no `out_valid`; the next frame of 5 (last) gives `out_sum`=5, `out_count`=1.
- **Reset mid-frame:** `rst_n` low after 2 products → all outputs 0 asynchronously; the following frame sums from 0.
- **Count saturation:** `COUNT_WIDTH`=2, six products of 1 → `out_count`=3, `out_sum`=6.
